fibonacci_lanes: RTL and testbench



---
 rtl/fib_pkg.sv | 13 +
 rtl/fib_step.sv | 56 +++++
 rtl/fibonacci_lanes.sv | 191 +++++++++++++++++++
 tb/tb_fibonacci_lanes.sv | 236 +++++++++++++++++++++++
 4 files changed

// File: rtl/fib_pkg.sv
// Shared types and limits for the multi-lane Fibonacci stream source.
package fib_pkg;

    // Controller states: waiting for a start command, or streaming beats.
    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    // Largest supported number of terms per beat.
    localparam int MAX_LANES = 4;

endpackage

// File: rtl/fib_step.sv
// Combinational adder chain. From two consecutive terms (a, b) it produces the
// LANES terms of one beat and the two terms that seed the following beat.
// Every term carries a taint bit: carry-out of its own addition OR either operand's taint.
module fib_step #(
    parameter int WIDTH = 16,
    parameter int LANES = 2
) (
    input  logic [WIDTH-1:0]       a_i,
    input  logic [WIDTH-1:0]       b_i,
    input  logic                   ta_i,
    input  logic                   tb_i,
    output logic [LANES*WIDTH-1:0] lanes_o,
    output logic [LANES-1:0]       lane_taint_o,
    output logic [WIDTH-1:0]       next_a_o,
    output logic [WIDTH-1:0]       next_b_o,
    output logic                   next_ta_o,
    output logic                   next_tb_o
);

    localparam int N = LANES + 2;

    logic [N-1:0][WIDTH-1:0] term;
    logic [N-1:0]            taint;
    logic [WIDTH:0]          sum;

    // Build terms t(base) .. t(base+LANES+1) with their taints.
    always_comb begin
        term     = '0;
        taint    = '0;
        sum      = '0;
        term[0]  = a_i;
        term[1]  = b_i;
        taint[0] = ta_i;
        taint[1] = tb_i;
        for (int k = 2; k < N; k++) begin
            sum      = {1'b0, term[k-1]} + {1'b0, term[k-2]};
            term[k]  = sum[WIDTH-1:0];
            taint[k] = sum[WIDTH] | taint[k-1] | taint[k-2];
        end
    end

    // Split the chain into beat lanes and the next-beat seeds.
    always_comb begin
        lanes_o      = '0;
        lane_taint_o = '0;
        for (int i = 0; i < LANES; i++) begin
            lanes_o[i*WIDTH +: WIDTH] = term[i];
            lane_taint_o[i]           = taint[i];
        end
        next_a_o  = term[LANES];
        next_b_o  = term[LANES+1];
        next_ta_o = taint[LANES];
        next_tb_o = taint[LANES+1];
    end

endmodule

// File: rtl/fibonacci_lanes.sv
// Fibonacci stream source: LANES consecutive terms per valid/ready beat.
// Stream contract: a beat transfers on a cycle where out_valid_o & out_ready_i;
// while out_valid_o is high and out_ready_i low, the beat (num/mask/last) holds
// unchanged and out_valid_o stays high until the transfer.
// a_q/b_q hold the first two terms of the beat after the one on the outputs;
// rem_q counts terms still to emit, including the beat currently shown.
// LANES must lie in 1..MAX_LANES.
module fibonacci_lanes
    import fib_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int LANES = 2,
    parameter int CNT_W = 16
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   start_i,
    input  logic [WIDTH-1:0]       seed_a_i,
    input  logic [WIDTH-1:0]       seed_b_i,
    input  logic [CNT_W-1:0]       count_i,
    output logic                   busy_o,
    output logic                   out_valid_o,
    input  logic                   out_ready_i,
    output logic [LANES*WIDTH-1:0] out_num_o,
    output logic [LANES-1:0]       out_mask_o,
    output logic                   out_last_o,
    output logic                   done_o,
    output logic                   overflow_o,
    output state_t                 state_o
);

    state_t                 state_q, state_d;
    logic [WIDTH-1:0]       a_q, a_d, b_q, b_d;
    logic                   ta_q, ta_d, tb_q, tb_d;
    logic [CNT_W-1:0]       rem_q, rem_d;
    logic [LANES*WIDTH-1:0] num_q, num_d;
    logic [LANES-1:0]       mask_q, mask_d;
    logic [LANES-1:0]       lt_q, lt_d;
    logic                   last_q, last_d;
    logic                   done_q, done_d;
    logic                   ovf_q, ovf_d;

    logic                   accept;
    logic [WIDTH-1:0]       step_a, step_b;
    logic                   step_ta, step_tb;
    logic [LANES*WIDTH-1:0] step_lanes;
    logic [LANES-1:0]       step_lt;
    logic [WIDTH-1:0]       step_na, step_nb;
    logic                   step_nta, step_ntb;
    logic [CNT_W-1:0]       beat_rem;
    logic [LANES-1:0]       beat_mask;
    logic [LANES*WIDTH-1:0] beat_num;

    // A start is only taken while idle; the seeds then feed the chain directly
    // so the first beat is registered on the accepting edge.
    assign accept  = (state_q == IDLE) && start_i;
    assign step_a  = accept ? seed_a_i : a_q;
    assign step_b  = accept ? seed_b_i : b_q;
    assign step_ta = accept ? 1'b0 : ta_q;
    assign step_tb = accept ? 1'b0 : tb_q;

    fib_step #(.WIDTH(WIDTH), .LANES(LANES)) u_step (
        .a_i          (step_a),
        .b_i          (step_b),
        .ta_i         (step_ta),
        .tb_i         (step_tb),
        .lanes_o      (step_lanes),
        .lane_taint_o (step_lt),
        .next_a_o     (step_na),
        .next_b_o     (step_nb),
        .next_ta_o    (step_nta),
        .next_tb_o    (step_ntb)
    );

    // Candidate next beat: remaining count, lane mask and zeroed unused lanes.
    always_comb begin
        beat_rem  = accept ? count_i : (rem_q - CNT_W'(LANES));
        beat_mask = '0;
        beat_num  = '0;
        for (int i = 0; i < LANES; i++) begin
            beat_mask[i] = (CNT_W'(i) < beat_rem);
            if (beat_mask[i]) begin
                beat_num[i*WIDTH +: WIDTH] = step_lanes[i*WIDTH +: WIDTH];
            end
        end
    end

    // Next-state logic: start acceptance, beat advance, final handshake.
    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        ta_d    = ta_q;
        tb_d    = tb_q;
        rem_d   = rem_q;
        num_d   = num_q;
        mask_d  = mask_q;
        lt_d    = lt_q;
        last_d  = last_q;
        done_d  = 1'b0;
        ovf_d   = ovf_q;
        case (state_q)
            IDLE: begin
                if (start_i) begin
                    ovf_d = 1'b0;
                    if (count_i == '0) begin
                        done_d = 1'b1;
                    end else begin
                        state_d = RUN;
                        rem_d   = beat_rem;
                        num_d   = beat_num;
                        mask_d  = beat_mask;
                        lt_d    = step_lt & beat_mask;
                        last_d  = (beat_rem <= CNT_W'(LANES));
                        a_d     = step_na;
                        b_d     = step_nb;
                        ta_d    = step_nta;
                        tb_d    = step_ntb;
                    end
                end
            end
            RUN: begin
                if (out_ready_i) begin
                    if (|lt_q) begin
                        ovf_d = 1'b1;
                    end
                    if (rem_q <= CNT_W'(LANES)) begin
                        state_d = IDLE;
                        done_d  = 1'b1;
                        num_d   = '0;
                        mask_d  = '0;
                        lt_d    = '0;
                        last_d  = 1'b0;
                    end else begin
                        rem_d  = beat_rem;
                        num_d  = beat_num;
                        mask_d = beat_mask;
                        lt_d   = step_lt & beat_mask;
                        last_d = (beat_rem <= CNT_W'(LANES));
                        a_d    = step_na;
                        b_d    = step_nb;
                        ta_d   = step_nta;
                        tb_d   = step_ntb;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State and output registers; reset aborts any sequence without a done pulse.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            a_q     <= '0;
            b_q     <= '0;
            ta_q    <= 1'b0;
            tb_q    <= 1'b0;
            rem_q   <= '0;
            num_q   <= '0;
            mask_q  <= '0;
            lt_q    <= '0;
            last_q  <= 1'b0;
            done_q  <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            ta_q    <= ta_d;
            tb_q    <= tb_d;
            rem_q   <= rem_d;
            num_q   <= num_d;
            mask_q  <= mask_d;
            lt_q    <= lt_d;
            last_q  <= last_d;
            done_q  <= done_d;
            ovf_q   <= ovf_d;
        end
    end

    assign busy_o      = (state_q == RUN);
    assign out_valid_o = (state_q == RUN);
    assign out_num_o   = num_q;
    assign out_mask_o  = mask_q;
    assign out_last_o  = last_q;
    assign done_o      = done_q;
    assign overflow_o  = ovf_q;
    assign state_o     = state_q;

endmodule

// File: tb/tb_fibonacci_lanes.sv
// Bench for fibonacci_lanes (WIDTH=16, LANES=2): scoreboard of expected beats
// built from an integer reference sequence, plus directed timing checks.
module tb_fibonacci_lanes;
    import fib_pkg::*;

    localparam int W  = 16;
    localparam int L  = 2;
    localparam int CW = 16;
    localparam int BW = 1 + L + L * W;

    // Clock / reset
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic          start = 1'b0;
    logic [W-1:0]  seed_a = '0;
    logic [W-1:0]  seed_b = '0;
    logic [CW-1:0] count = '0;
    logic          out_ready = 1'b1;
    logic          busy, out_valid, out_last, done, overflow;
    logic [L*W-1:0] out_num;
    logic [L-1:0]  out_mask;
    state_t        state;

    fibonacci_lanes #(.WIDTH(W), .LANES(L), .CNT_W(CW)) dut (
        .clk         (clk),
        .rst         (rst),
        .start_i     (start),
        .seed_a_i    (seed_a),
        .seed_b_i    (seed_b),
        .count_i     (count),
        .busy_o      (busy),
        .out_valid_o (out_valid),
        .out_ready_i (out_ready),
        .out_num_o   (out_num),
        .out_mask_o  (out_mask),
        .out_last_o  (out_last),
        .done_o      (done),
        .overflow_o  (overflow),
        .state_o     (state)
    );

    // Scoreboard
    logic [BW-1:0] exp_q[$];
    logic          ovf_exp_q[$];
    int            n_cmp = 0;
    int            n_bad = 0;
    logic [BW-1:0] held = '0;
    logic          held_v = 1'b0;
    wire  [BW-1:0] beat = {out_last, out_mask, out_num};

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Reference: true integer terms; a lane is tainted iff its true value wrapped.
    task automatic push_seq(input logic [W-1:0] sa, input logic [W-1:0] sb, input int cnt);
        longint        tv[64];
        logic [BW-1:0] bt;
        logic          ovf;
        int            nb;
        int            k;
        ovf   = 1'b0;
        tv[0] = longint'(sa);
        tv[1] = longint'(sb);
        for (int m = 2; m < cnt; m++) tv[m] = tv[m-1] + tv[m-2];
        nb = (cnt + L - 1) / L;
        for (int j = 0; j < nb; j++) begin
            bt = '0;
            for (int i = 0; i < L; i++) begin
                k = j * L + i;
                if (k < cnt) begin
                    bt[i*W +: W] = tv[k][W-1:0];
                    bt[L*W + i]  = 1'b1;
                    if (tv[k] >= (longint'(1) << W)) ovf = 1'b1;
                end
            end
            bt[BW-1] = (j == nb - 1);
            exp_q.push_back(bt);
        end
        ovf_exp_q.push_back(ovf);
    endtask

    // Monitor: compares handshaked beats, checks hold under backpressure and done.
    always @(negedge clk) begin
        if (rst) begin
            exp_q.delete();
            ovf_exp_q.delete();
            held_v = 1'b0;
        end else begin
            if (out_valid) begin
                if (held_v) check_eq("hold", beat, held);
                if (out_ready) begin
                    held_v = 1'b0;
                    if (exp_q.size() == 0) check_eq("extra_beat", out_valid, 0);
                    else check_eq("beat", beat, exp_q.pop_front());
                end else begin
                    held_v = 1'b1;
                    held   = beat;
                end
            end
            if (done) begin
                if (ovf_exp_q.size() == 0) check_eq("spurious_done", done, 0);
                else begin
                    check_eq("ovf_at_done", overflow, ovf_exp_q.pop_front());
                    check_eq("beats_left", exp_q.size(), 0);
                end
            end
        end
    end

    // Driver tasks
    task automatic do_start(input logic [W-1:0] sa, input logic [W-1:0] sb, input int cnt,
                            output bit acc);
        @(posedge clk); #1;
        start  = 1'b1;
        seed_a = sa;
        seed_b = sb;
        count  = CW'(cnt);
        acc    = !busy;
        if (acc) push_seq(sa, sb, cnt);
        @(posedge clk); #1;
        start = 1'b0;
        if (acc) check_eq("lat_valid", out_valid, (cnt != 0));
    endtask

    task automatic wait_done(input int budget, input bit rnd_ready);
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < budget; i++) begin
            @(posedge clk); #1;
            if (rnd_ready) out_ready = 1'($urandom_range(0, 1));
            if (done) begin
                seen = 1'b1;
                break;
            end
        end
        out_ready = 1'b1;
        check_eq("done_timeout", seen, 1);
    endtask

    bit acc;
    int rc;

    initial begin
        // Reset state
        repeat (3) @(posedge clk);
        #1;
        check_eq("rst_valid", out_valid, 0);
        check_eq("rst_busy", busy, 0);
        check_eq("rst_done", done, 0);
        check_eq("rst_ovf", overflow, 0);
        check_eq("rst_num", out_num, 0);
        check_eq("rst_mask", out_mask, 0);
        check_eq("rst_last", out_last, 0);
        check_eq("rst_state", state, IDLE);
        rst = 1'b0;

        // Full beats, done in N+4
        do_start(16'd1, 16'd1, 6, acc);
        @(posedge clk); #1;
        @(posedge clk); #1;
        check_eq("t1_last_n3", out_last, 1);
        check_eq("t1_nodone_n3", done, 0);
        @(posedge clk); #1;
        check_eq("t1_done_n4", done, 1);
        check_eq("t1_busy_n4", busy, 0);
        check_eq("t1_ovf", overflow, 0);

        // Partial final beat
        do_start(16'd1, 16'd1, 5, acc);
        wait_done(20, 1'b0);

        // Backpressure on the first beat for three cycles
        out_ready = 1'b0;
        do_start(16'd1, 16'd1, 6, acc);
        @(posedge clk); #1;
        @(posedge clk); #1;
        check_eq("bp_valid", out_valid, 1);
        @(posedge clk); #1;
        out_ready = 1'b1;
        wait_done(20, 1'b0);

        // Overflow boundary and clear on start
        do_start(16'd1, 16'd1, 24, acc);
        wait_done(40, 1'b0);
        check_eq("ovf24", overflow, 0);
        do_start(16'd1, 16'd1, 25, acc);
        wait_done(40, 1'b0);
        check_eq("ovf25", overflow, 1);
        do_start(16'd3, 16'd4, 2, acc);
        check_eq("ovf_clear", overflow, 0);
        wait_done(20, 1'b0);

        // Zero count, then start while busy
        do_start(16'd5, 16'd6, 0, acc);
        check_eq("zero_done", done, 1);
        do_start(16'd1, 16'd2, 10, acc);
        do_start(16'd9, 16'd9, 3, acc);
        check_eq("busy_ignore", acc, 0);
        wait_done(40, 1'b0);

        // Reset mid-run after beat 1
        do_start(16'd1, 16'd1, 10, acc);
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        check_eq("mr_valid", out_valid, 0);
        check_eq("mr_busy", busy, 0);
        check_eq("mr_ovf", overflow, 0);
        check_eq("mr_done", done, 0);
        @(posedge clk); #1;
        check_eq("mr_done2", done, 0);
        do_start(16'd2, 16'd3, 4, acc);
        wait_done(20, 1'b0);

        // Random seeds, counts and ready
        for (int r = 0; r < 8; r++) begin
            rc = int'($urandom_range(0, 30));
            do_start(W'($urandom_range(0, 65535)), W'($urandom_range(0, 65535)), rc, acc);
            if (rc != 0) wait_done(200, 1'b1);
        end

        repeat (3) @(posedge clk);
        #1;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
